instruction_fetch: RTL and testbench
====================================

# instruction_fetch

Fetch front end for the rv32i core: drives word addresses into the synchronous instruction memory and consumes its registered read data one cycle later. Delivers (pc, instruction) pairs to decode over a valid/ready handshake. Handles back-pressure through a 2-entry output buffer and handles control-flow redirects by flushing in-flight and buffered fetches.

## Interface
- RESET_PC, 32'h00000000, first fetch address after reset; bits [1:0] must be 0.
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- mem_addr  out  32  fetch address to the instruction memory. Memory returns the word at mem_addr>>2 on mem_instr after the next rising edge.
- mem_instr  in  32  registered read data from the instruction memory.
- redirect_valid  in  1  taken branch/jump; restart fetch at redirect_pc.
- redirect_pc  in  32  new fetch address; bits [1:0] are ignored and treated as 00.
- out_valid  out  1  out_pc/out_instr hold a valid fetched pair.
- out_ready  in  1  decode accepts the pair this cycle.
- out_pc  out  32  address of the presented instruction.
- out_instr  out  32  presented instruction word.

## Operation
- State:
  - fetch_pc: next address to issue.
  - inflight_valid, inflight_pc: address issued last cycle, whose data is on mem_instr this cycle.
  - 2-entry FIFO of {pc, instr} with count 0..2.
- pop = out_valid & out_ready & ~redirect_valid.
- issue = ~rst & (redirect_valid | (count - pop + inflight_valid < 2)).
- mem_addr = redirect_valid ? {redirect_pc[31:2], 2'b00} : fetch_pc. The memory reads every cycle; only issued addresses are tracked.
- On issue:
  - inflight_valid <= 1 and inflight_pc <= mem_addr.
  - fetch_pc <= mem_addr + 4, modulo 2^32, so 32'hFFFFFFFC wraps to 0.
- Otherwise inflight_valid <= 0 and fetch_pc holds.
- Normal cycle (no redirect):
  - If inflight_valid, push {inflight_pc, mem_instr} into the FIFO.
  - If pop, remove the FIFO head.
  - Push and pop may occur in the same cycle.
  - The issue rule guarantees the FIFO never overflows; overflow is unreachable.
- Redirect cycle:
  - FIFO count <= 0.
  - The current mem_instr is discarded and is not pushed.
  - The redirect target is issued in that same cycle.
  - No pop occurs even if out_ready = 1; out_valid is forced to 0 that cycle.
- out_valid = (count != 0) & ~redirect_valid. out_pc and out_instr show the FIFO head.
- While out_valid = 1 and out_ready = 0, out_pc and out_instr must be held stable.
- Reset:
  - fetch_pc <= RESET_PC, inflight_valid <= 0, count <= 0, so out_valid = 0.
  - rst overrides redirect_valid.
  - Reset mid-stream drops all buffered and in-flight fetches.

## Timing
- Cycle 0 is the first cycle with rst = 0.
  - Cycle 0: mem_addr = RESET_PC and the address is issued.
  - Cycle 1: data is on mem_instr and is pushed at the end of the cycle.
  - Cycle 2: out_valid = 1.
- Issue-to-out_valid latency is 2 cycles. Redirect-to-first-valid is also 2 cycles: redirect in cycle t, target presented in cycle t+2.
- Throughput is 1 instruction/cycle sustained while out_ready = 1.
- When out_ready deasserts, at most the FIFO fills to 2 entries. Issue then stops until space frees; no instruction is lost or duplicated.
- After out_ready reasserts, the next issue occurs the same cycle as the first pop. Up to 2 buffered entries cover the memory latency, so there are no bubbles.

## Test plan
- Memory model word i = 32'hA000_0000 + i, with RESET_PC = 0.
  - Release reset and hold out_ready = 1.
  - Expected: out_valid first rises in cycle 2; pairs (0, A0000000), (4, A0000001), (8, A0000002)… appear on consecutive cycles with no gaps.
- Back-pressure:
  - Drop out_ready for 5 cycles mid-stream, then restore it.
  - Expected: out_pc/out_instr are stable while stalled, count never exceeds 2, and the sequence resumes with no skipped or repeated pc, with no bubble on resume.
- Redirect:
  - Assert redirect_valid with redirect_pc = 32'h40 while entries are buffered and one fetch is in flight.
  - Expected: out_valid = 0 in the redirect cycle and the next cycle; (40, A0000010) appears 2 cycles later, then (44, A0000011).
- Redirect with redirect_pc = 32'h43 and out_ready = 1:
  - Expected: fetch restarts at 32'h40, and no handshake is counted in the redirect cycle.
- Wraparound with RESET_PC = 32'hFFFFFFF8:
  - Expected: pcs run FFFFFFF8, FFFFFFFC, 00000000, 00000004.
- Reset mid-stream with redirect_valid also high:
  - Expected: out_valid = 0 the next cycle, and fetch restarts at RESET_PC with the cycle-2 latency above.

Source files
------------

// File: rtl/instruction_fetch.sv
// Instruction fetch front end: issues word addresses to a synchronous
// instruction memory, captures the returned word one cycle later into a
// 2-entry output buffer and presents (pc, instr) pairs to decode over a
// valid/ready handshake. A redirect flushes everything and restarts fetch.
module instruction_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] mem_addr,
    input  logic [31:0] mem_instr,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_pc,
    output logic [31:0] out_instr
);

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_t;

    logic [31:0] fetch_pc;
    logic        inflight_valid;
    logic [31:0] inflight_pc;

    fetch_t      fifo [2];
    logic        head;
    logic [1:0]  count;

    logic        pop;
    logic        issue;
    logic [2:0]  occ;

    // Handshake, issue throttling and the address presented to memory
    always_comb begin
        out_valid = (count != 2'd0) & ~redirect_valid;
        pop       = out_valid & out_ready;
        // Slots that will be occupied once the current in-flight word lands;
        // issuing only while this is below 2 keeps the buffer from overflowing.
        occ       = {1'b0, count} + {2'b00, inflight_valid} - {2'b00, pop};
        issue     = ~rst & (redirect_valid | (occ < 3'd2));
        mem_addr  = redirect_valid ? (redirect_pc & ~32'h3) : fetch_pc;
        out_pc    = fifo[head].pc;
        out_instr = fifo[head].instr;
    end

    // Fetch pointer, in-flight tracking and buffer occupancy
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc       <= RESET_PC;
            inflight_valid <= 1'b0;
            inflight_pc    <= RESET_PC;
            count          <= 2'd0;
            head           <= 1'b0;
        end else begin
            if (issue) begin
                inflight_valid <= 1'b1;
                inflight_pc    <= mem_addr;
                fetch_pc       <= mem_addr + 32'd4;
            end else begin
                inflight_valid <= 1'b0;
            end
            if (redirect_valid) begin
                // Buffered entries and the word now on mem_instr are stale.
                count <= 2'd0;
                head  <= 1'b0;
            end else begin
                if (pop)
                    head <= ~head;
                count <= count + {1'b0, inflight_valid} - {1'b0, pop};
            end
        end
    end

    // Buffer storage: the landing word goes to the slot behind the head.
    // A full buffer never coincides with an in-flight word, so no overwrite.
    always_ff @(posedge clk) begin
        if (!rst && !redirect_valid && inflight_valid)
            fifo[head ^ count[0]] <= '{pc: inflight_pc, instr: mem_instr};
    end

endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: memory model word i = A000_0000 + i, a
// stream-level reference model checked every cycle, and directed scenarios
// (startup, back-pressure, redirects, wraparound, reset mid-stream).
module tb_instruction_fetch;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] mem_addr, mem_instr;
    logic        redir;
    logic [31:0] rpc;
    logic        out_valid, out_ready;
    logic [31:0] out_pc, out_instr;

    // second instance exercising address wraparound
    logic [31:0] w_mem_addr, w_mem_instr;
    logic        w_redir = 1'b0;
    logic [31:0] w_rpc = 32'h0;
    logic        w_ready = 1'b1;
    logic        w_valid;
    logic [31:0] w_pc, w_instr;

    int n_chk = 0;
    int n_fail = 0;

    instruction_fetch #(.RESET_PC(32'h0000_0000)) dut (
        .clk(clk), .rst(rst), .mem_addr(mem_addr), .mem_instr(mem_instr),
        .redirect_valid(redir), .redirect_pc(rpc),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_pc(out_pc), .out_instr(out_instr)
    );

    instruction_fetch #(.RESET_PC(32'hFFFF_FFF8)) dut_wrap (
        .clk(clk), .rst(rst), .mem_addr(w_mem_addr), .mem_instr(w_mem_instr),
        .redirect_valid(w_redir), .redirect_pc(w_rpc),
        .out_valid(w_valid), .out_ready(w_ready),
        .out_pc(w_pc), .out_instr(w_instr)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] word_at(input logic [31:0] a);
        return 32'hA000_0000 + (a >> 2);
    endfunction

    // synchronous instruction memories
    always @(posedge clk) begin
        mem_instr   <= word_at(mem_addr);
        w_mem_instr <= word_at(w_mem_addr);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Reference model: the delivered stream is consecutive words starting at
    // the last restart point; output is valid from 2 cycles after a restart
    // and never drops afterwards (buffer covers memory latency).
    logic [31:0] exp_pc = 32'h0;
    int          age = 0;
    logic        prev_rst = 1'b0;
    logic        prev_stall = 1'b0;
    logic [31:0] prev_pc, prev_instr;

    initial forever begin
        @(negedge clk);
        if (rst) begin
            if (prev_rst) chk("valid_in_reset", {31'b0, out_valid}, 32'd0);
        end else begin
            logic exp_v;
            exp_v = (age >= 2) && !redir;
            chk("out_valid", {31'b0, out_valid}, {31'b0, exp_v});
            if (out_valid && exp_v) begin
                chk("out_pc", out_pc, exp_pc);
                chk("out_instr", out_instr, word_at(exp_pc));
            end
            if (prev_stall && !redir) begin
                chk("stall_hold_pc", out_pc, prev_pc);
                chk("stall_hold_instr", out_instr, prev_instr);
            end
        end
        prev_stall = !rst && out_valid && !out_ready;
        prev_pc    = out_pc;
        prev_instr = out_instr;
        if (rst) begin
            exp_pc = 32'h0;
            age    = 0;
        end else if (redir) begin
            exp_pc = rpc & ~32'h3;
            age    = 1;
        end else begin
            if (out_valid && out_ready) exp_pc += 32'd4;
            if (age < 15) age++;
        end
        prev_rst = rst;
    end

    initial begin
        rst = 1'b1; redir = 1'b0; rpc = 32'h0; out_ready = 1'b1;
        step(3);
        rst = 1'b0;                      // cycle 0
        @(negedge clk);
        chk("cyc0_valid", {31'b0, out_valid}, 32'd0);
        chk("cyc0_addr", mem_addr, 32'h0);
        step(2);                         // cycle 2 onward
        for (int k = 0; k < 4; k++) begin
            logic [31:0] wpcs [4];
            wpcs = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0000_0000, 32'h0000_0004};
            @(negedge clk);
            chk("start_valid", {31'b0, out_valid}, 32'd1);
            chk("start_pc", out_pc, 32'(4 * k));
            chk("start_instr", out_instr, 32'hA000_0000 + 32'(k));
            chk("wrap_valid", {31'b0, w_valid}, 32'd1);
            chk("wrap_pc", w_pc, wpcs[k]);
            step(1);
        end

        // back-pressure for 5 cycles
        out_ready = 1'b0;
        step(5);
        out_ready = 1'b1;
        step(4);

        // redirect with one buffered entry and one fetch in flight
        redir = 1'b1; rpc = 32'h40;
        @(negedge clk);
        chk("redir_cyc_valid", {31'b0, out_valid}, 32'd0);
        step(1);
        redir = 1'b0;
        @(negedge clk);
        chk("redir_next_valid", {31'b0, out_valid}, 32'd0);
        step(1);
        @(negedge clk);
        chk("redir_pc0", out_pc, 32'h40);
        chk("redir_instr0", out_instr, 32'hA000_0010);
        step(1);
        @(negedge clk);
        chk("redir_pc1", out_pc, 32'h44);
        chk("redir_instr1", out_instr, 32'hA000_0011);
        step(3);

        // misaligned redirect target with decode ready
        redir = 1'b1; rpc = 32'h43;
        @(negedge clk);
        chk("redir43_addr", mem_addr, 32'h40);
        step(1);
        redir = 1'b0;
        step(1);
        @(negedge clk);
        chk("redir43_pc", out_pc, 32'h40);
        step(3);

        // redirect during a stall
        out_ready = 1'b0;
        step(2);
        redir = 1'b1; rpc = 32'h100;
        step(1);
        redir = 1'b0;
        step(3);
        out_ready = 1'b1;
        step(3);

        // reset mid-stream with a redirect competing
        rst = 1'b1; redir = 1'b1; rpc = 32'h80;
        step(1);
        rst = 1'b0; redir = 1'b0;
        @(negedge clk);
        chk("rst_next_valid", {31'b0, out_valid}, 32'd0);
        chk("rst_restart_addr", mem_addr, 32'h0);
        step(2);
        @(negedge clk);
        chk("rst_restart_pc", out_pc, 32'h0);
        chk("rst_restart_valid", {31'b0, out_valid}, 32'd1);

        // random back-pressure tail, checked by the model
        for (int i = 0; i < 40; i++) begin
            step(1);
            out_ready = 1'($urandom_range(0, 1));
        end
        out_ready = 1'b1;
        step(3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
